// File: rtl/pong_ball.sv
// Pong ball engine: serve sequencing, per-frame ball motion, wall and paddle
// bounces, miss detection and score/hit pulses. All outputs are registered.
module pong_ball #(
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480,
  parameter int unsigned BALL_SIZE   = 8,
  parameter int unsigned PADDLE_W    = 8,
  parameter int unsigned PADDLE_H    = 64,
  parameter int unsigned SPEED_X     = 2,
  parameter int unsigned SPEED_Y     = 1,
  parameter int unsigned SERVE_DELAY = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        serve,
  input  logic [9:0]  player_paddle_x,
  input  logic [9:0]  player_paddle_y,
  input  logic [9:0]  ai_paddle_x,
  input  logic [9:0]  ai_paddle_y,
  output logic [19:0] ball_state,
  output logic        ball_active,
  output logic        hit_pulse,
  output logic        player_score_pulse,
  output logic        ai_score_pulse
);

  localparam int unsigned CntW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

  localparam logic [9:0]      CenterX  = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0]      CenterY  = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [10:0]     BottomY  = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0]     ScreenW  = 11'(SCREEN_W);
  localparam logic [10:0]     BallSz   = 11'(BALL_SIZE);
  localparam logic [10:0]     PadW     = 11'(PADDLE_W);
  localparam logic [10:0]     PadH     = 11'(PADDLE_H);
  localparam logic [10:0]     SpdX     = 11'(SPEED_X);
  localparam logic [10:0]     SpdY     = 11'(SPEED_Y);
  localparam logic [CntW-1:0] CntLast  = CntW'(SERVE_DELAY - 1);

  typedef enum logic [1:0] {
    StIdle,
    StServeWait,
    StMove,
    StScored
  } state_e;

  state_e          state_q, state_d;
  logic [9:0]      x_q, x_d;
  logic [9:0]      y_q, y_d;
  logic            dir_right_q, dir_right_d;
  logic            dir_down_q, dir_down_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            hit_q, hit_d;
  logic            pscore_q, pscore_d;
  logic            ascore_q, ascore_d;

  // 11-bit working copies so sums never wrap.
  logic [10:0] bx, by, px, py, ax, ay;
  assign bx = {1'b0, x_q};
  assign by = {1'b0, y_q};
  assign px = {1'b0, player_paddle_x};
  assign py = {1'b0, player_paddle_y};
  assign ax = {1'b0, ai_paddle_x};
  assign ay = {1'b0, ai_paddle_y};

  logic player_overlap, ai_overlap, left_hit, right_hit;

  assign player_overlap = (by + BallSz > py) && (by < py + PadH);
  assign ai_overlap     = (by + BallSz > ay) && (by < ay + PadH);

  // Face hits catch the ball anywhere within one step of the face.
  assign left_hit  = !dir_right_q && (bx >= px + PadW) && (bx <= px + PadW + SpdX)
                     && player_overlap;
  assign right_hit = dir_right_q && (bx + BallSz <= ax) && (bx + BallSz + SpdX >= ax)
                     && ai_overlap;

  logic [10:0] mv_x, mv_y;
  logic        mv_dir_right, mv_dir_down;
  logic        mv_hit, mv_ai_score, mv_player_score;

  // Clamp an 11-bit coordinate back into the 10-bit register range.
  function automatic logic [9:0] clamp10(input logic [10:0] v);
    return v[10] ? 10'h3FF : v[9:0];
  endfunction

  // Vertical step: walls reflect and pin the ball to the edge.
  always_comb begin
    mv_y        = by;
    mv_dir_down = dir_down_q;
    if (dir_down_q) begin
      if (by + SpdY >= BottomY) begin
        mv_y        = BottomY;
        mv_dir_down = 1'b0;
      end else begin
        mv_y = by + SpdY;
      end
    end else begin
      if (by < SpdY) begin
        mv_y        = '0;
        mv_dir_down = 1'b1;
      end else begin
        mv_y = by - SpdY;
      end
    end
  end

  // Horizontal step: paddle hits take priority over misses.
  always_comb begin
    mv_x            = bx;
    mv_dir_right    = dir_right_q;
    mv_hit          = 1'b0;
    mv_ai_score     = 1'b0;
    mv_player_score = 1'b0;
    if (left_hit) begin
      mv_x         = px + PadW;
      mv_dir_right = 1'b1;
      mv_hit       = 1'b1;
    end else if (right_hit) begin
      mv_x         = ax - BallSz;
      mv_dir_right = 1'b0;
      mv_hit       = 1'b1;
    end else if (!dir_right_q && (bx <= SpdX)) begin
      mv_ai_score = 1'b1;
    end else if (dir_right_q && (bx + BallSz + SpdX >= ScreenW)) begin
      mv_player_score = 1'b1;
    end else if (dir_right_q) begin
      mv_x = bx + SpdX;
    end else begin
      mv_x = bx - SpdX;
    end
  end

  // Next-state logic for the serve/play sequence and ball registers.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dir_right_d = dir_right_q;
    dir_down_d  = dir_down_q;
    cnt_d       = cnt_q;
    hit_d       = 1'b0;
    pscore_d    = 1'b0;
    ascore_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (serve) begin
          state_d = StServeWait;
          cnt_d   = '0;
        end
      end
      StServeWait: begin
        if (frame_tick) begin
          if (cnt_q == CntLast) begin
            state_d = StMove;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StMove: begin
        if (frame_tick) begin
          x_d         = clamp10(mv_x);
          y_d         = clamp10(mv_y);
          dir_right_d = mv_dir_right;
          dir_down_d  = mv_dir_down;
          hit_d       = mv_hit;
          if (mv_ai_score || mv_player_score) begin
            state_d     = StScored;
            x_d         = CenterX;
            y_d         = CenterY;
            ascore_d    = mv_ai_score;
            pscore_d    = mv_player_score;
            // Re-serve toward whoever conceded.
            dir_right_d = mv_player_score;
          end
        end
      end
      StScored: begin
        if (frame_tick) begin
          state_d = StServeWait;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      x_q         <= CenterX;
      y_q         <= CenterY;
      dir_right_q <= 1'b1;
      dir_down_q  <= 1'b1;
      cnt_q       <= '0;
      hit_q       <= 1'b0;
      pscore_q    <= 1'b0;
      ascore_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_right_q <= dir_right_d;
      dir_down_q  <= dir_down_d;
      cnt_q       <= cnt_d;
      hit_q       <= hit_d;
      pscore_q    <= pscore_d;
      ascore_q    <= ascore_d;
    end
  end

  assign ball_state         = {y_q, x_q};
  assign ball_active        = (state_q == StMove);
  assign hit_pulse          = hit_q;
  assign player_score_pulse = pscore_q;
  assign ai_score_pulse     = ascore_q;

endmodule

// File: tb/tb_pong_ball.sv
// Directed bench for pong_ball: serve timing, paddle and wall bounces,
// corner bounce, misses on both sides, re-serve direction and reset override.
module tb_pong_ball;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        serve;
  logic [9:0]  player_paddle_x, player_paddle_y, ai_paddle_x, ai_paddle_y;
  logic [19:0] ball_state;
  logic        ball_active, hit_pulse, player_score_pulse, ai_score_pulse;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int          hits;
  int          pulses;

  always #5 clk = ~clk;

  pong_ball dut (
    .clk                (clk),
    .reset              (reset),
    .frame_tick         (frame_tick),
    .serve              (serve),
    .player_paddle_x    (player_paddle_x),
    .player_paddle_y    (player_paddle_y),
    .ai_paddle_x        (ai_paddle_x),
    .ai_paddle_y        (ai_paddle_y),
    .ball_state         (ball_state),
    .ball_active        (ball_active),
    .hit_pulse          (hit_pulse),
    .player_score_pulse (player_score_pulse),
    .ai_score_pulse     (ai_score_pulse)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_ball(input string tag, input int ex, input int ey);
    check({tag, "_x"}, 32'(ball_state[9:0]), 32'(ex));
    check({tag, "_y"}, 32'(ball_state[19:10]), 32'(ey));
  endtask

  // Called at a negedge; returns at the next negedge with the tick's result visible.
  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic do_serve();
    serve = 1'b1;
    @(negedge clk);
    serve = 1'b0;
  endtask

  initial begin
    reset           = 1'b0;
    frame_tick      = 1'b0;
    serve           = 1'b0;
    player_paddle_x = 10'd296;
    player_paddle_y = 10'd0;
    ai_paddle_x     = 10'd336;
    ai_paddle_y     = 10'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    check_ball("rst", 316, 236);
    check("rst_active", 32'(ball_active), 32'd0);
    check("rst_hit", 32'(hit_pulse), 32'd0);
    check("rst_pscore", 32'(player_score_pulse), 32'd0);
    check("rst_ascore", 32'(ai_score_pulse), 32'd0);

    // Ticks in IDLE do nothing.
    repeat (3) tick();
    check_ball("idle", 316, 236);
    check("idle_active", 32'(ball_active), 32'd0);

    do_serve();
    for (int i = 1; i <= 59; i++) tick();
    check("wait59_active", 32'(ball_active), 32'd0);
    tick();
    check("wait60_active", 32'(ball_active), 32'd1);
    check_ball("wait60", 316, 236);

    // Paddles at x 296 (face 304) and 336 (face 328) bounce the ball every 12 ticks;
    // paddle y follows the known ball y so both always overlap.
    hits = 0;
    for (int k = 1; k <= 235; k++) begin
      player_paddle_y = 10'(215 + k);
      ai_paddle_y     = 10'(215 + k);
      tick();
      if (hit_pulse) hits++;
      if (k == 1) check_ball("move1", 318, 237);
      if (k == 6) begin
        check("hit6_pulse", 32'(hit_pulse), 32'd1);
        check_ball("hit6", 328, 242);
      end
    end
    check_ball("pre_corner", 306, 471);
    check("rally_hits", 32'(hits), 32'd20);

    // Corner: AI face hit and bottom wall on the same tick.
    ai_paddle_x     = 10'd315;
    player_paddle_y = 10'd451;
    ai_paddle_y     = 10'd451;
    tick();
    check_ball("corner", 307, 472);
    check("corner_hit", 32'(hit_pulse), 32'd1);
    @(negedge clk);
    check("corner_hit_width", 32'(hit_pulse), 32'd0);
    check_ball("corner_hold", 307, 472);

    player_paddle_y = 10'd452;
    ai_paddle_y     = 10'd452;
    tick();
    check_ball("after_corner", 305, 471);
    check("after_corner_hit", 32'(hit_pulse), 32'd0);

    // Player face hit one pixel inside the step window: snaps to the face.
    player_paddle_y = 10'd451;
    ai_paddle_y     = 10'd451;
    tick();
    check_ball("player_hit", 304, 470);
    check("player_hit_pulse", 32'(hit_pulse), 32'd1);

    player_paddle_y = 10'd450;
    ai_paddle_y     = 10'd450;
    tick();
    check_ball("near_ai", 306, 469);
    check("near_ai_hit", 32'(hit_pulse), 32'd0);

    player_paddle_y = 10'd449;
    ai_paddle_y     = 10'd449;
    tick();
    check_ball("ai_hit2", 307, 468);
    check("ai_hit2_pulse", 32'(hit_pulse), 32'd1);

    // Player paddle moved away: ball travels left to the edge and is missed.
    player_paddle_y = 10'd0;
    ai_paddle_y     = 10'd0;
    pulses          = 0;
    for (int k = 241; k <= 393; k++) begin
      tick();
      if (hit_pulse || ai_score_pulse || player_score_pulse) pulses++;
    end
    check_ball("pre_miss", 1, 315);
    check("travel_pulses", 32'(pulses), 32'd0);
    tick();
    check_ball("miss", 316, 236);
    check("miss_ascore", 32'(ai_score_pulse), 32'd1);
    check("miss_pscore", 32'(player_score_pulse), 32'd0);
    check("miss_active", 32'(ball_active), 32'd0);
    @(negedge clk);
    check("miss_ascore_width", 32'(ai_score_pulse), 32'd0);

    // Auto-serve: one tick leaves SCORED, then the full serve delay.
    tick();
    for (int i = 1; i <= 59; i++) tick();
    check("reserve59_active", 32'(ball_active), 32'd0);
    tick();
    check("reserve60_active", 32'(ball_active), 32'd1);
    tick();
    check_ball("reserve_move1", 314, 235);

    // Reset with a tick that would otherwise hit the player paddle.
    player_paddle_x = 10'd305;
    player_paddle_y = 10'd215;
    reset           = 1'b0;
    frame_tick      = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check_ball("midreset", 316, 236);
    check("midreset_active", 32'(ball_active), 32'd0);
    check("midreset_hit", 32'(hit_pulse), 32'd0);
    check("midreset_scores", 32'({player_score_pulse, ai_score_pulse}), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    tick();
    check_ball("post_reset_idle", 316, 236);
    check("post_reset_active", 32'(ball_active), 32'd0);

    // Right-edge miss with both paddles out of the ball's rows.
    player_paddle_y = 10'd0;
    ai_paddle_y     = 10'd0;
    do_serve();
    for (int i = 1; i <= 60; i++) tick();
    for (int k = 1; k <= 157; k++) tick();
    check_ball("pre_pmiss", 630, 393);
    tick();
    check_ball("pmiss", 316, 236);
    check("pmiss_pscore", 32'(player_score_pulse), 32'd1);
    check("pmiss_ascore", 32'(ai_score_pulse), 32'd0);

    // Re-serve heads right (AI conceded), still moving down.
    tick();
    for (int i = 1; i <= 60; i++) tick();
    tick();
    check_ball("pserve_move1", 318, 237);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
